// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory, aligns its
// one-cycle read latency and applies static branch prediction (JAL, backward B-type).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_addrpred,
    output logic        imem_renable,
    output logic        imem_pause,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] imem_rdata_pred,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0]  OPCODE_BRCH = 7'b1100011;
    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_d_reg;
    logic        valid_d_reg;
    logic        pred_taken_d_reg;
    logic [31:0] pred_target_d_reg;

    logic [6:0]  opcode;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic        is_jal;
    logic        is_bwd_branch;
    logic        pred_taken;
    logic [31:0] pred_target;

    // Predecode the word at the current PC, which the memory returns combinationally.
    always_comb begin
        opcode        = imem_rdata_pred[6:0];
        imm_j         = {{12{imem_rdata_pred[31]}}, imem_rdata_pred[19:12], imem_rdata_pred[20],
                         imem_rdata_pred[30:21], 1'b0};
        imm_b         = {{20{imem_rdata_pred[31]}}, imem_rdata_pred[7], imem_rdata_pred[30:25],
                         imem_rdata_pred[11:8], 1'b0};
        is_jal        = (opcode == OPCODE_JAL);
        is_bwd_branch = (opcode == OPCODE_BRCH) && imem_rdata_pred[31];
        pred_taken    = PREDICT_EN && (is_jal || is_bwd_branch);
        pred_target   = (pc_reg + 32'd4) & WORD_MASK;
        if (pred_taken) begin
            pred_target = (pc_reg + (is_jal ? imm_j : imm_b)) & WORD_MASK;
        end
    end

    always_comb begin
        pc_next = pred_target;
        if (redirect) begin
            pc_next = redirect_pc & WORD_MASK;
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg            <= RESET_PC;
            pc_d_reg          <= 32'd0;
            valid_d_reg       <= 1'b0;
            pred_taken_d_reg  <= 1'b0;
            pred_target_d_reg <= 32'd0;
        end else begin
            pc_reg <= pc_next;
            if (!stall) begin
                pc_d_reg          <= pc_reg;
                pred_taken_d_reg  <= pred_taken;
                pred_target_d_reg <= pred_target;
            end
            // A redirect kills the word in flight even while the pipe is held.
            if (redirect) begin
                valid_d_reg <= 1'b0;
            end else if (!stall) begin
                valid_d_reg <= 1'b1;
            end
        end
    end

    assign imem_addr      = pc_reg;
    assign imem_addrpred  = pc_reg;
    assign imem_renable   = ~rst;
    assign imem_pause     = stall;

    assign if_pc          = pc_d_reg;
    assign if_valid       = valid_d_reg;
    assign if_pred_taken  = pred_taken_d_reg & valid_d_reg;
    assign if_pred_target = pred_target_d_reg;
    assign if_instr       = valid_d_reg ? imem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus a scoreboard of expected fetched words,
// with a second instance built with static prediction disabled.
module tb_fetch_unit;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_40  = 32'h0400_006F;
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
    localparam logic [31:0] BNE_P16 = 32'h0000_1863;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [31:0] imem_addr, imem_addrpred, if_instr, if_pc, if_pred_target;
    logic        imem_renable, imem_pause, if_valid, if_pred_taken;
    logic [31:0] imem_rdata, imem_rdata_pred;

    logic [31:0] np_imem_addr, np_imem_addrpred, np_if_instr, np_if_pc, np_if_pred_target;
    logic        np_imem_renable, np_imem_pause, np_if_valid, np_if_pred_taken;
    logic [31:0] np_imem_rdata, np_imem_rdata_pred;

    logic [31:0] mem [0:1023];
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held_instr;

    fetch_unit #(.RESET_PC(32'h0), .PREDICT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_addrpred(imem_addrpred), .imem_renable(imem_renable),
        .imem_pause(imem_pause), .imem_rdata(imem_rdata), .imem_rdata_pred(imem_rdata_pred),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target)
    );

    fetch_unit #(.RESET_PC(32'h0), .PREDICT_EN(1'b0)) dut_np (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(np_imem_addr), .imem_addrpred(np_imem_addrpred), .imem_renable(np_imem_renable),
        .imem_pause(np_imem_pause), .imem_rdata(np_imem_rdata), .imem_rdata_pred(np_imem_rdata_pred),
        .if_instr(np_if_instr), .if_pc(np_if_pc), .if_valid(np_if_valid),
        .if_pred_taken(np_if_pred_taken), .if_pred_target(np_if_pred_target)
    );

    always #5 clk = ~clk;

    assign imem_rdata_pred    = mem[imem_addrpred[11:2]];
    assign np_imem_rdata_pred = mem[np_imem_addrpred[11:2]];

    always @(posedge clk) begin
        if (imem_renable && !imem_pause) imem_rdata <= mem[imem_addr[11:2]];
        if (np_imem_renable && !np_imem_pause) np_imem_rdata <= mem[np_imem_addr[11:2]];
    end

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return mem[addr[11:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        exp_t x;
        x.pc = pc; x.instr = word_at(pc); x.taken = taken; x.target = target;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 32'h0 || imem_renable !== 1'b0 || if_valid !== 1'b0 ||
            if_instr !== NOP || if_pc !== 32'h0 || if_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: addr=%h ren=%b valid=%b instr=%h pc=%h pt=%b, required addr=0 ren=0 valid=0 instr=%h pc=0 pt=0",
                     imem_addr, imem_renable, if_valid, if_instr, if_pc, if_pred_taken, NOP);
        end
        tick();
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (if_valid !== 1'b0 || imem_renable !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: valid=%b ren=%b, required valid=0 ren=1", if_valid, imem_renable);
        end
        $display("reset: checked reset values and release");
    endtask

    task automatic test_stream();
        push_exp(32'h0, 1'b0, 32'h4);
        push_exp(32'h4, 1'b0, 32'h8);
        push_exp(32'h8, 1'b0, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d valid=%b queued=%0d, required valid=1", i, if_valid, sb.size());
            end else begin
                e = sb.pop_front();
                checks++;
                if (if_pc !== e.pc || if_instr !== e.instr || if_pred_taken !== e.taken || if_pred_target !== e.target) begin
                    errors++;
                    $display("FAIL stream_word: pc=%h instr=%h pt=%b tgt=%h, required pc=%h instr=%h pt=%b tgt=%h",
                             if_pc, if_instr, if_pred_taken, if_pred_target, e.pc, e.instr, e.taken, e.target);
                end
            end
            $display("stream: if_pc=%h if_instr=%h valid=%b", if_pc, if_instr, if_valid);
        end
    endtask

    task automatic test_stall();
        held_instr = word_at(32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_pc !== 32'h8 || if_instr !== held_instr || if_valid !== 1'b1 || imem_pause !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: pc=%h instr=%h valid=%b pause=%b, required pc=8 instr=%h valid=1 pause=1",
                         if_pc, if_instr, if_valid, imem_pause, held_instr);
            end
            $display("stall: cycle %0d if_pc=%h", i, if_pc);
        end
        stall = 1'b0;
        push_exp(32'hC, 1'b0, 32'h10);
        tick();
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL stall_queue: queue empty, required one entry");
        end else begin
            e = sb.pop_front();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
                errors++;
                $display("FAIL stall_release: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                         if_valid, if_pc, if_instr, e.pc, e.instr);
            end
        end
        $display("stall release: if_pc=%h", if_pc);
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_squash: valid=%b instr=%h addr=%h, required valid=0 instr=%h addr=100",
                     if_valid, if_instr, imem_addr, NOP);
        end
        push_exp(32'h100, 1'b0, 32'h104);
        tick();
        e = sb.pop_front();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                     if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        $display("redirect: if_pc=%h valid=%b", if_pc, if_valid);
    endtask

    task automatic test_jal();
        redirect = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 32'h20) begin
            errors++;
            $display("FAIL jal_addr0: addr=%h, required 00000020", imem_addr);
        end
        push_exp(32'h20, 1'b1, 32'h60);
        push_exp(32'h60, 1'b0, 32'h64);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (imem_addr !== 32'h60) begin
                    errors++;
                    $display("FAIL jal_addr1: addr=%h, required 00000060", imem_addr);
                end
            end
            e = sb.pop_front();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr ||
                if_pred_taken !== e.taken || if_pred_target !== e.target) begin
                errors++;
                $display("FAIL jal_word: valid=%b pc=%h instr=%h pt=%b tgt=%h, required valid=1 pc=%h instr=%h pt=%b tgt=%h",
                         if_valid, if_pc, if_instr, if_pred_taken, if_pred_target, e.pc, e.instr, e.taken, e.target);
            end
            $display("jal: if_pc=%h pred_taken=%b target=%h", if_pc, if_pred_taken, if_pred_target);
        end
    endtask

    task automatic test_branches();
        logic [31:0] br_pc [2];
        logic [31:0] br_next [2];
        logic        br_taken [2];
        br_pc[0] = 32'h80; br_next[0] = 32'h78; br_taken[0] = 1'b1;
        br_pc[1] = 32'h90; br_next[1] = 32'h94; br_taken[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            redirect = 1'b1;
            redirect_pc = br_pc[i];
            tick();
            redirect = 1'b0;
            push_exp(br_pc[i], br_taken[i], br_next[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (imem_addr !== br_next[i] || if_valid !== 1'b1 || if_pc !== e.pc ||
                if_instr !== e.instr || if_pred_taken !== e.taken || if_pred_target !== e.target) begin
                errors++;
                $display("FAIL branch_pred: addr=%h pc=%h instr=%h pt=%b tgt=%h, required addr=%h pc=%h instr=%h pt=%b tgt=%h",
                         imem_addr, if_pc, if_instr, if_pred_taken, if_pred_target,
                         br_next[i], e.pc, e.instr, e.taken, e.target);
            end
            checks++;
            if (np_imem_addr !== br_pc[i] + 32'd4 || np_if_pc !== br_pc[i] ||
                np_if_valid !== 1'b1 || np_if_pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL branch_nopred: addr=%h pc=%h valid=%b pt=%b, required addr=%h pc=%h valid=1 pt=0",
                         np_imem_addr, np_if_pc, np_if_valid, np_if_pred_taken, br_pc[i] + 32'd4, br_pc[i]);
            end
            $display("branch: pc=%h next=%h pred_taken=%b nopred_next=%h", if_pc, imem_addr, if_pred_taken, np_imem_addr);
        end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1;
        stall = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        checks++;
        if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_stall: addr=%h valid=%b, required addr=00000200 valid=0", imem_addr, if_valid);
        end
        push_exp(32'h200, 1'b0, 32'h204);
        tick();
        e = sb.pop_front();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            errors++;
            $display("FAIL redirect_stall_word: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                     if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        $display("redirect+stall: if_pc=%h valid=%b", if_pc, if_valid);
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        push_exp(32'hFFFF_FFFC, 1'b0, 32'h0);
        push_exp(32'h0, 1'b0, 32'h4);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr || if_pred_target !== e.target) begin
                errors++;
                $display("FAIL wrap: valid=%b pc=%h instr=%h tgt=%h, required valid=1 pc=%h instr=%h tgt=%h",
                         if_valid, if_pc, if_instr, if_pred_target, e.pc, e.instr, e.target);
            end
            $display("wrap: if_pc=%h imem_addr=%h", if_pc, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 32'h0 || imem_renable !== 1'b0 || if_valid !== 1'b0 ||
            if_instr !== NOP || if_pc !== 32'h0 || if_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%h ren=%b valid=%b instr=%h pc=%h pt=%b, required addr=0 ren=0 valid=0 instr=%h pc=0 pt=0",
                     imem_addr, imem_renable, if_valid, if_instr, if_pc, if_pred_taken, NOP);
        end
        sb.delete();
        tick();
        rst = 1'b0;
        push_exp(32'h0, 1'b0, 32'h4);
        tick();
        e = sb.pop_front();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            errors++;
            $display("FAIL async_reset_restart: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                     if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        $display("async reset: restart if_pc=%h valid=%b", if_pc, if_valid);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {i[11:0], 5'd0, 3'd0, 5'd1, 7'b0010011};
        end
        mem[32'h20 >> 2] = JAL_40;
        mem[32'h80 >> 2] = BEQ_M8;
        mem[32'h90 >> 2] = BNE_P16;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_jal();
        test_branches();
        test_redirect_stall();
        test_wrap();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
